ex_stage_unit: RTL and testbench

EX_STAGE_UNIT -- requirements
Module: ex_stage_unit

---
 rtl/ex_stage_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_ex_stage_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, single-cycle ALU and a 32-step iterative
// multiplier that stalls the front of the pipeline. Results are registered into EX/MEM.
module ex_stage_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wbIn,
  input  logic [1:0]  mIn,
  input  logic [3:0]  exIn,
  input  logic [31:0] readData1In,
  input  logic [31:0] readData2In,
  input  logic [31:0] extendedAdrIn,
  input  logic [4:0]  rsIn,
  input  logic [4:0]  rtIn,
  input  logic [4:0]  rdIn,
  input  logic        exMemRegWrite,
  input  logic [4:0]  exMemRd,
  input  logic [31:0] exMemData,
  input  logic        memWbRegWrite,
  input  logic [4:0]  memWbRd,
  input  logic [31:0] memWbData,
  output logic        stall,
  output logic [1:0]  wbOut,
  output logic [1:0]  mOut,
  output logic [31:0] aluResultOut,
  output logic [31:0] writeDataOut,
  output logic [4:0]  writeRegOut
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    OpAdd,
    OpSub,
    OpAnd,
    OpOr,
    OpSlt,
    OpMul,
    OpNone
  } op_e;

  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctSlt  = 6'h2A;
  localparam logic [5:0] FunctMult = 6'h18;

  logic        reg_dst;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [5:0]  funct;

  logic [31:0] op_a;
  logic [31:0] rt_fwd;
  logic [31:0] op_b;
  logic [4:0]  write_reg;
  op_e         op;
  logic [31:0] alu_result;
  logic        is_mult;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] wdata_lat_q, wdata_lat_d;

  logic [1:0]  wb_q, wb_d;
  logic [1:0]  m_q, m_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        stall_int;

  assign reg_dst = exIn[3];
  assign alu_src = exIn[2];
  assign alu_op  = exIn[1:0];
  assign funct   = extendedAdrIn[5:0];

  // Forward rs into opA; EX/MEM wins over MEM/WB, register 0 never forwards.
  always_comb begin
    op_a = readData1In;
    if (exMemRegWrite && (exMemRd != 5'd0) && (exMemRd == rsIn)) begin
      op_a = exMemData;
    end else if (memWbRegWrite && (memWbRd != 5'd0) && (memWbRd == rsIn)) begin
      op_a = memWbData;
    end
  end

  // Forward rt with the same priority; feeds both opB and the store data.
  always_comb begin
    rt_fwd = readData2In;
    if (exMemRegWrite && (exMemRd != 5'd0) && (exMemRd == rtIn)) begin
      rt_fwd = exMemData;
    end else if (memWbRegWrite && (memWbRd != 5'd0) && (memWbRd == rtIn)) begin
      rt_fwd = memWbData;
    end
  end

  assign op_b      = alu_src ? extendedAdrIn : rt_fwd;
  assign write_reg = reg_dst ? rdIn : rtIn;

  // Decode aluOp, falling through to funct for R-type instructions.
  always_comb begin
    op = OpNone;
    unique case (alu_op)
      2'b00: op = OpAdd;
      2'b01: op = OpSub;
      2'b11: op = OpSlt;
      2'b10: begin
        case (funct)
          FunctAdd:  op = OpAdd;
          FunctSub:  op = OpSub;
          FunctAnd:  op = OpAnd;
          FunctOr:   op = OpOr;
          FunctSlt:  op = OpSlt;
          FunctMult: op = OpMul;
          default:   op = OpNone;
        endcase
      end
    endcase
  end

  assign is_mult = (op == OpMul);

  // Single-cycle ALU; mult is handled by the iterative datapath instead.
  always_comb begin
    alu_result = 32'd0;
    case (op)
      OpAdd:   alu_result = op_a + op_b;
      OpSub:   alu_result = op_a - op_b;
      OpAnd:   alu_result = op_a & op_b;
      OpOr:    alu_result = op_a | op_b;
      OpSlt:   alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  // Next-state, multiplier step and EX/MEM load selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    wdata_lat_d = wdata_lat_q;
    stall_int   = 1'b0;
    wb_d        = 2'd0;
    m_d         = 2'd0;
    alu_d       = 32'd0;
    wdata_d     = 32'd0;
    wreg_d      = 5'd0;

    unique case (state_q)
      StIdle: begin
        if (is_mult) begin
          // Latch operands now; forwarding sources move on while we iterate.
          stall_int   = 1'b1;
          mcand_d     = op_a;
          mplier_d    = op_b;
          prod_d      = 32'd0;
          wdata_lat_d = rt_fwd;
          cnt_d       = 5'd0;
          state_d     = StBusy;
        end else begin
          wb_d    = wbIn;
          m_d     = mIn;
          alu_d   = alu_result;
          wdata_d = rt_fwd;
          wreg_d  = write_reg;
        end
      end
      StBusy: begin
        stall_int = 1'b1;
        prod_d    = prod_q + (mplier_q[0] ? mcand_q : 32'd0);
        mcand_d   = {mcand_q[30:0], 1'b0};
        mplier_d  = {1'b0, mplier_q[31:1]};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Held instruction is retired here; IDLE sees the next one.
        wb_d    = wbIn;
        m_d     = mIn;
        alu_d   = prod_q;
        wdata_d = wdata_lat_q;
        wreg_d  = write_reg;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Stall is forced low during reset so the front end is never frozen by a stale state.
  assign stall = rst & stall_int;

  // State, multiplier and EX/MEM registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      mcand_q     <= 32'd0;
      mplier_q    <= 32'd0;
      prod_q      <= 32'd0;
      wdata_lat_q <= 32'd0;
      wb_q        <= 2'd0;
      m_q         <= 2'd0;
      alu_q       <= 32'd0;
      wdata_q     <= 32'd0;
      wreg_q      <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      wdata_lat_q <= wdata_lat_d;
      wb_q        <= wb_d;
      m_q         <= m_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      wreg_q      <= wreg_d;
    end
  end

  assign wbOut        = wb_q;
  assign mOut         = m_q;
  assign aluResultOut = alu_q;
  assign writeDataOut = wdata_q;
  assign writeRegOut  = wreg_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wbIn;
  logic [1:0]  mIn;
  logic [3:0]  exIn;
  logic [31:0] readData1In;
  logic [31:0] readData2In;
  logic [31:0] extendedAdrIn;
  logic [4:0]  rsIn;
  logic [4:0]  rtIn;
  logic [4:0]  rdIn;
  logic        exMemRegWrite;
  logic [4:0]  exMemRd;
  logic [31:0] exMemData;
  logic        memWbRegWrite;
  logic [4:0]  memWbRd;
  logic [31:0] memWbData;
  logic        stall;
  logic [1:0]  wbOut;
  logic [1:0]  mOut;
  logic [31:0] aluResultOut;
  logic [31:0] writeDataOut;
  logic [4:0]  writeRegOut;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage_unit dut (
    .clk           (clk),
    .rst           (rst),
    .wbIn          (wbIn),
    .mIn           (mIn),
    .exIn          (exIn),
    .readData1In   (readData1In),
    .readData2In   (readData2In),
    .extendedAdrIn (extendedAdrIn),
    .rsIn          (rsIn),
    .rtIn          (rtIn),
    .rdIn          (rdIn),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemData     (exMemData),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbData     (memWbData),
    .stall         (stall),
    .wbOut         (wbOut),
    .mOut          (mOut),
    .aluResultOut  (aluResultOut),
    .writeDataOut  (writeDataOut),
    .writeRegOut   (writeRegOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: value a source register sees after forwarding.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf_val);
    if (exMemRegWrite && exMemRd != 0 && exMemRd == r) return exMemData;
    if (memWbRegWrite && memWbRd != 0 && memWbRd == r) return memWbData;
    return rf_val;
  endfunction

  function automatic bit model_is_mult();
    return (exIn[1:0] == 2'b10) && (extendedAdrIn[5:0] == 6'h18);
  endfunction

  // Reference ALU computed directly from the operation table.
  function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (exIn[1:0])
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return (sa < sb) ? 32'd1 : 32'd0;
      default: begin
        case (extendedAdrIn[5:0])
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
          6'h18: return a * b;
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] model_opb();
    return exIn[2] ? extendedAdrIn : fwd(rtIn, readData2In);
  endfunction

  task automatic clear_inputs();
    wbIn = 2'b00; mIn = 2'b00; exIn = 4'b0000;
    readData1In = 0; readData2In = 0; extendedAdrIn = 0;
    rsIn = 0; rtIn = 0; rdIn = 0;
    exMemRegWrite = 0; exMemRd = 0; exMemData = 0;
    memWbRegWrite = 0; memWbRd = 0; memWbData = 0;
  endtask

  // One non-mult op: stall stays low, everything lands on the next edge.
  task automatic run_single(input string tag);
    logic [31:0] a, rt, exp;
    logic [4:0]  wr;
    logic [1:0]  wb, m;
    a   = fwd(rsIn, readData1In);
    rt  = fwd(rtIn, readData2In);
    exp = model_alu(a, model_opb());
    wr  = exIn[3] ? rdIn : rtIn;
    wb  = wbIn;
    m   = mIn;
    #1;
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".alu"}, aluResultOut, exp);
    chk({tag, ".wdata"}, writeDataOut, rt);
    chk({tag, ".wreg"}, {27'd0, writeRegOut}, {27'd0, wr});
    chk({tag, ".wbm"}, {28'd0, wbOut, mOut}, {28'd0, wb, m});
  endtask

  // One mult: 33 stall cycles with bubbles, then the product on the following edge.
  task automatic run_mult(input string tag);
    logic [31:0] exp;
    logic [4:0]  wr;
    logic [1:0]  wb, m;
    int cnt;
    exp = fwd(rsIn, readData1In) * model_opb();
    wr  = exIn[3] ? rdIn : rtIn;
    wb  = wbIn;
    m   = mIn;
    #1;
    chk({tag, ".stall_issue"}, {31'd0, stall}, 32'd1);
    cnt = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      // Operands were latched at issue, so forwarding data may change freely.
      exMemData     = $urandom;
      memWbData     = $urandom;
      exMemRegWrite = 1'($urandom_range(0, 1));
      #1;
      if (!stall) break;
      cnt++;
      chk({tag, ".bubble"}, {28'd0, wbOut, mOut}, 32'd0);
    end
    chk({tag, ".stall_cycles"}, cnt, 33);
    @(posedge clk); #1;
    chk({tag, ".prod"}, aluResultOut, exp);
    chk({tag, ".wreg"}, {27'd0, writeRegOut}, {27'd0, wr});
    chk({tag, ".wbm"}, {28'd0, wbOut, mOut}, {28'd0, wb, m});
  endtask

  task automatic randomize_op(input bit want_mult);
    logic [5:0] functs [8];
    logic [5:0] f;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h00, 6'h27};
    wbIn = 2'($urandom); mIn = 2'($urandom);
    readData1In = $urandom; readData2In = $urandom;
    rsIn = 5'($urandom_range(0, 3)); rtIn = 5'($urandom_range(0, 3));
    rdIn = 5'($urandom);
    exMemRegWrite = 1'($urandom_range(0, 1)); exMemRd = 5'($urandom_range(0, 3));
    exMemData = $urandom;
    memWbRegWrite = 1'($urandom_range(0, 1)); memWbRd = 5'($urandom_range(0, 3));
    memWbData = $urandom;
    if (want_mult) begin
      f = 6'h18;
      exIn = {1'($urandom), 1'($urandom), 2'b10};
    end else begin
      f = functs[$urandom_range(0, 7)];
      exIn = {1'($urandom), 1'($urandom), 2'($urandom)};
    end
    extendedAdrIn = {$urandom} & 32'hFFFF_FFC0 | {26'd0, f};
  endtask

  initial begin
    logic [31:0] lit;
    clear_inputs();
    rst = 1'b0;
    // Present a mult during reset: stall must stay low.
    exIn = 4'b0010; extendedAdrIn = 32'h18;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.outs", {26'd0, wbOut, mOut, writeRegOut}, 32'd0);
    chk("reset.alu", aluResultOut, 32'd0);
    chk("reset.wdata", writeDataOut, 32'd0);
    rst = 1'b1;
    clear_inputs();

    // Immediate add 5 + 7 into rt=3.
    clear_inputs();
    wbIn = 2'b10; mIn = 2'b01; exIn = 4'b0100;
    readData1In = 5; extendedAdrIn = 7; rtIn = 3; rdIn = 9;
    run_single("add_imm");
    lit = 12; chk("add_imm.lit", aluResultOut, lit);

    // EX/MEM forwarding beats MEM/WB.
    clear_inputs();
    exIn = 4'b0100; extendedAdrIn = 1; rsIn = 4; readData1In = 50;
    exMemRegWrite = 1; exMemRd = 4; exMemData = 100;
    memWbRegWrite = 1; memWbRd = 4; memWbData = 9;
    run_single("fwd_ex");
    lit = 101; chk("fwd_ex.lit", aluResultOut, lit);

    // Register 0 never forwards.
    rsIn = 0; exMemRd = 0; memWbRd = 0;
    run_single("fwd_r0");
    lit = 51; chk("fwd_r0.lit", aluResultOut, lit);

    // MEM/WB forwarding when EX/MEM is not writing.
    rsIn = 4; exMemRd = 4; memWbRd = 4; exMemRegWrite = 0;
    run_single("fwd_wb");
    lit = 10; chk("fwd_wb.lit", aluResultOut, lit);

    // Signed slt: -1 < 1.
    clear_inputs();
    exIn = 4'b1010; extendedAdrIn = 32'h2A; readData1In = 32'hFFFF_FFFF; readData2In = 1;
    rdIn = 7;
    run_single("slt_neg");
    lit = 1; chk("slt_neg.lit", aluResultOut, lit);

    // 0 - 1 wraps.
    extendedAdrIn = 32'h22; readData1In = 0; readData2In = 1;
    run_single("sub_wrap");
    lit = 32'hFFFF_FFFF; chk("sub_wrap.lit", aluResultOut, lit);

    // 6 * 7 through the multiplier.
    clear_inputs();
    wbIn = 2'b11; mIn = 2'b10; exIn = 4'b1010; extendedAdrIn = 32'h18;
    readData1In = 6; readData2In = 7; rsIn = 1; rtIn = 2; rdIn = 5;
    run_mult("mult_6x7");
    lit = 42; chk("mult_6x7.lit", aluResultOut, lit);

    // Low word of 0xFFFFFFFF * 2.
    clear_inputs();
    wbIn = 2'b10; exIn = 4'b1010; extendedAdrIn = 32'h18;
    readData1In = 32'hFFFF_FFFF; readData2In = 2; rsIn = 1; rtIn = 2; rdIn = 6;
    run_mult("mult_wrap");
    lit = 32'hFFFF_FFFE; chk("mult_wrap.lit", aluResultOut, lit);

    // Back-to-back mults each take the full latency.
    clear_inputs();
    exIn = 4'b1010; extendedAdrIn = 32'h18; readData1In = 3; readData2In = 5; rdIn = 1;
    run_mult("mult_b2b_0");
    readData1In = 11; readData2In = 13;
    exMemRegWrite = 0; memWbRegWrite = 0;
    run_mult("mult_b2b_1");

    // Reset in the middle of a multiply.
    clear_inputs();
    wbIn = 2'b11; mIn = 2'b11; exIn = 4'b1010; extendedAdrIn = 32'h18;
    readData1In = 9; readData2In = 9; rdIn = 4;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_busy.stall_in_rst", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("rst_busy.outs", {26'd0, wbOut, mOut, writeRegOut}, 32'd0);
    chk("rst_busy.alu", aluResultOut, 32'd0);
    chk("rst_busy.wdata", writeDataOut, 32'd0);
    rst = 1'b1;
    clear_inputs();
    wbIn = 2'b10; exIn = 4'b0100; readData1In = 20; extendedAdrIn = 22; rtIn = 8;
    run_single("rst_busy.add");
    lit = 42; chk("rst_busy.add_lit", aluResultOut, lit);

    // Randomized single-cycle ops.
    for (int i = 0; i < 40; i++) begin
      randomize_op(1'b0);
      run_single("rand_op");
    end

    // Randomized mults.
    for (int i = 0; i < 3; i++) begin
      randomize_op(1'b1);
      if (model_is_mult()) run_mult("rand_mult");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
